id_stage: RTL and testbench

Parametrised instruction-decode stage for the five-stage MIPS pipeline. It decodes the opcode into WB/M/EX control fields and holds the register file. It sign- or zero-extends the immediate and latches everything into the ID/EX pipeline register. Beyond the earlier decode stage, it adds configurable data width and register count, load-use hazard detection with stall and bubble insertion, branch flush, a valid bit, and an optional WB-to-ID register-file bypass.

---
 rtl/id_pkg.sv | 77 +++++++
 rtl/id_regfile.sv | 64 ++++++
 rtl/id_stage.sv | 153 +++++++++++++++
 tb/tb_id_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// ============================================================================
// id_pkg : opcode, ALU-op and control-field definitions shared by the ID stage
// Revision 1.0
// ============================================================================
`default_nettype none

package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  // Bit positions inside wb_ctlout / m_ctlout
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (op)
      OP_RTYPE: begin
        c.regdst = 1'b1; c.aluop = ALUOP_FUNCT; c.regwrite = 1'b1;
      end
      OP_LW: begin
        c.alusrc = 1'b1; c.aluop = ALUOP_ADD; c.memread = 1'b1;
        c.regwrite = 1'b1; c.memtoreg = 1'b1;
      end
      OP_SW: begin
        c.alusrc = 1'b1; c.aluop = ALUOP_ADD; c.memwrite = 1'b1;
      end
      OP_BEQ: begin
        c.aluop = ALUOP_SUB; c.branch = 1'b1;
      end
      OP_ADDI: begin
        c.alusrc = 1'b1; c.aluop = ALUOP_ADD; c.regwrite = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        c.alusrc = 1'b1; c.aluop = ALUOP_LOGIC; c.regwrite = 1'b1;
      end
      default: c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

  // Opcodes whose rt field is a source operand rather than a destination
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_regfile.sv
// ============================================================================
// id_regfile : NREGS x XLEN register file, 2 async read / 1 sync write port
// Optional feature macro: ID_BYPASS_EN (write-through from WB to read ports)
// Revision 1.0
// ============================================================================
`default_nettype none

module id_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4:0]               raddr1_i,
  input  logic [4:0]               raddr2_i,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [XLEN-1:0]          wdata_i,
  output logic [XLEN-1:0]          rdata1_o,
  output logic [XLEN-1:0]          rdata2_o
);

  localparam int RW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [4:0]      raddr  [2];
  logic [XLEN-1:0] rdata  [2];
  logic [4:0]      waddr_ext;
  logic            wr_en;

  assign waddr_ext = 5'(waddr_i);
  assign wr_en     = we_i && (waddr_i != '0) && (32'(waddr_i) < 32'(NREGS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign raddr[0] = raddr1_i;
  assign raddr[1] = raddr2_i;
  assign rdata1_o = rdata[0];
  assign rdata2_o = rdata[1];

  for (genvar p = 0; p < 2; p++) begin : g_rport
    always_comb begin
      rdata[p] = '0;
      if ((raddr[p] != 5'd0) && (32'(raddr[p]) < 32'(NREGS)))
        rdata[p] = regs_q[raddr[p][RW-1:0]];
`ifdef ID_BYPASS_EN
      if (we_i && (waddr_ext == raddr[p]) && (raddr[p] != 5'd0))
        rdata[p] = wdata_i;
`else
      if (1'b0 && (waddr_ext == raddr[p]))
        rdata[p] = wdata_i;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// id_stage : MIPS instruction decode, register file, load-use hazard, ID/EX reg
// Optional feature macro: ID_BYPASS_EN (passed to id_regfile)
// Revision 1.0
// ============================================================================
`default_nettype none

module id_stage
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              IF_ID_instrout,
  input  logic [XLEN-1:0]          IF_ID_npcout,
  input  logic                     IF_ID_valid,
  input  logic                     EX_flush,
  input  logic [$clog2(NREGS)-1:0] MEM_WB_rd,
  input  logic                     MEM_WB_regwrite,
  input  logic [XLEN-1:0]          WB_mux5_writedata,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [1:0]               wb_ctlout,
  output logic [2:0]               m_ctlout,
  output logic                     regdst,
  output logic                     alusrc,
  output logic [1:0]               aluop,
  output logic [XLEN-1:0]          npcout,
  output logic [XLEN-1:0]          rdata1out,
  output logic [XLEN-1:0]          rdata2out,
  output logic [XLEN-1:0]          s_extendout,
  output logic [$clog2(NREGS)-1:0] instrout_2521,
  output logic [$clog2(NREGS)-1:0] instrout_2016,
  output logic [$clog2(NREGS)-1:0] instrout_1511
);

  localparam int RW = $clog2(NREGS);

  logic [5:0]      opcode;
  logic [RW-1:0]   rs, rt, rd;
  logic [15:0]     imm;
  ctrl_t           ctrl;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            hazard;

  ctrl_t           ctrl_q,   ctrl_d;
  logic            valid_q,  valid_d;
  logic [XLEN-1:0] npc_q,    npc_d;
  logic [XLEN-1:0] rd1_q,    rd1_d;
  logic [XLEN-1:0] rd2_q,    rd2_d;
  logic [XLEN-1:0] ext_q,    ext_d;
  logic [RW-1:0]   rs_q,     rs_d;
  logic [RW-1:0]   rt_q,     rt_d;
  logic [RW-1:0]   rdf_q,    rdf_d;

  assign opcode = IF_ID_instrout[31:26];
  assign rs     = IF_ID_instrout[21 +: RW];
  assign rt     = IF_ID_instrout[16 +: RW];
  assign rd     = IF_ID_instrout[11 +: RW];
  assign imm    = IF_ID_instrout[15:0];
  assign ctrl   = decode(opcode);

  // Logical immediates are unsigned; everything else sign-extends
  assign ext = ((opcode == OP_ANDI) || (opcode == OP_ORI))
             ? {{(XLEN-16){1'b0}}, imm}
             : {{(XLEN-16){imm[15]}}, imm};

  id_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1_i (IF_ID_instrout[25:21]),
    .raddr2_i (IF_ID_instrout[20:16]),
    .we_i     (MEM_WB_regwrite),
    .waddr_i  (MEM_WB_rd),
    .wdata_i  (WB_mux5_writedata),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign hazard = valid_q && ctrl_q.memread && (rt_q != '0) && IF_ID_valid &&
                  ((rt_q == rs) || ((rt_q == rt) && uses_rt(opcode)));
  assign stall  = hazard && !EX_flush;

  always_comb begin
    ctrl_d  = CTRL_BUBBLE;
    valid_d = 1'b0;
    npc_d   = '0;
    rd1_d   = '0;
    rd2_d   = '0;
    ext_d   = '0;
    rs_d    = '0;
    rt_d    = '0;
    rdf_d   = '0;
    if (!EX_flush && !hazard) begin
      ctrl_d  = IF_ID_valid ? ctrl : CTRL_BUBBLE;
      valid_d = IF_ID_valid;
      npc_d   = IF_ID_npcout;
      rd1_d   = rdata1;
      rd2_d   = rdata2;
      ext_d   = ext;
      rs_d    = rs;
      rt_d    = rt;
      rdf_d   = rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      npc_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ext_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rdf_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      npc_q   <= npc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      ext_q   <= ext_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rdf_q   <= rdf_d;
    end
  end

  assign ex_valid      = valid_q;
  assign wb_ctlout     = {ctrl_q.regwrite, ctrl_q.memtoreg};
  assign m_ctlout      = {ctrl_q.branch, ctrl_q.memread, ctrl_q.memwrite};
  assign regdst        = ctrl_q.regdst;
  assign alusrc        = ctrl_q.alusrc;
  assign aluop         = ctrl_q.aluop;
  assign npcout        = npc_q;
  assign rdata1out     = rd1_q;
  assign rdata2out     = rd2_q;
  assign s_extendout   = ext_q;
  assign instrout_2521 = rs_q;
  assign instrout_2016 = rt_q;
  assign instrout_1511 = rdf_q;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// tb_id_stage : directed self-checking bench for id_stage (32/32 and 64/16)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_id_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        valid;
  logic        flush;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;

  logic        a_stall, a_exv, a_regdst, a_alusrc;
  logic [1:0]  a_wb, a_aluop;
  logic [2:0]  a_m;
  logic [31:0] a_npc, a_rd1, a_rd2, a_ext;
  logic [4:0]  a_rs, a_rt, a_rdf;

  logic        b_stall, b_exv, b_regdst, b_alusrc;
  logic [1:0]  b_wb, b_aluop;
  logic [2:0]  b_m;
  logic [63:0] b_npc, b_rd1, b_rd2, b_ext;
  logic [3:0]  b_rs, b_rt, b_rdf;

  int n_assert = 0;
  int n_fail   = 0;

  id_stage #(.XLEN(32), .NREGS(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .IF_ID_instrout(instr), .IF_ID_npcout(npc),
    .IF_ID_valid(valid), .EX_flush(flush), .MEM_WB_rd(wb_rd),
    .MEM_WB_regwrite(wb_we), .WB_mux5_writedata(wb_data),
    .stall(a_stall), .ex_valid(a_exv), .wb_ctlout(a_wb), .m_ctlout(a_m),
    .regdst(a_regdst), .alusrc(a_alusrc), .aluop(a_aluop), .npcout(a_npc),
    .rdata1out(a_rd1), .rdata2out(a_rd2), .s_extendout(a_ext),
    .instrout_2521(a_rs), .instrout_2016(a_rt), .instrout_1511(a_rdf)
  );

  id_stage #(.XLEN(64), .NREGS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .IF_ID_instrout(instr), .IF_ID_npcout({32'b0, npc}),
    .IF_ID_valid(valid), .EX_flush(flush), .MEM_WB_rd(wb_rd[3:0]),
    .MEM_WB_regwrite(wb_we), .WB_mux5_writedata({32'b0, wb_data}),
    .stall(b_stall), .ex_valid(b_exv), .wb_ctlout(b_wb), .m_ctlout(b_m),
    .regdst(b_regdst), .alusrc(b_alusrc), .aluop(b_aluop), .npcout(b_npc),
    .rdata1out(b_rd1), .rdata2out(b_rd2), .s_extendout(b_ext),
    .instrout_2521(b_rs), .instrout_2016(b_rt), .instrout_1511(b_rdf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic id(input logic [31:0] ins, input logic v);
    instr = ins;
    valid = v;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_we   = we;
    wb_rd   = rd;
    wb_data = data;
  endtask

  logic [31:0] bypass_exp;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    npc   = 32'h0000_0040;
    id(r_type(5'd3, 5'd3, 5'd1), 1'b1);
    wb(1'b1, 5'd5, 32'hCAFE_0005);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", a_exv, 0);
    chk("rst_wb", a_wb, 0);
    chk("rst_m", a_m, 0);
    chk("rst_regdst", a_regdst, 0);
    chk("rst_aluop", a_aluop, 0);
    chk("rst_npc", a_npc, 0);
    chk("rst_rdata1", a_rd1, 0);
    chk("rst_rd_field", a_rdf, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_b_ext", b_ext, 0);

    id(32'h0, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;

    id(r_type(5'd5, 5'd0, 5'd6), 1'b1);
    tick();
    chk("r5_reads_zero", a_rd1, 0);
    chk("ex_valid_after_rst", a_exv, 1);

    id(32'h0, 1'b0);
    wb(1'b1, 5'd3, 32'h0000_1234);
    tick();
    chk("invalid_no_ctrl", a_wb, 0);

    npc = 32'h0000_0100;
    id(r_type(5'd3, 5'd3, 5'd1), 1'b1);
    wb(1'b1, 5'd0, 32'h0000_DEAD);
    tick();
    chk("add_rdata1", a_rd1, 32'h1234);
    chk("add_rdata2", a_rd2, 32'h1234);
    chk("add_wb", a_wb, 2'b10);
    chk("add_aluop", a_aluop, 2'b10);
    chk("add_regdst", a_regdst, 1);
    chk("add_alusrc", a_alusrc, 0);
    chk("add_m", a_m, 0);
    chk("add_rd_field", a_rdf, 1);
    chk("add_npc", a_npc, 32'h100);
    chk("b_r3_read", b_rd1, 64'h1234);

    id(r_type(5'd19, 5'd0, 5'd1), 1'b1);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("r0_write_dropped", a_rd2, 0);
    chk("b_idx19_reads_zero", b_rd1, 0);

    id(i_type(6'b100011, 5'd1, 5'd2, 16'h0000), 1'b1);
    tick();
    chk("lw_m", a_m, 3'b010);
    chk("lw_wb", a_wb, 2'b11);
    chk("lw_alusrc", a_alusrc, 1);
    chk("lw_rt_field", a_rt, 2);
    id(r_type(5'd2, 5'd5, 5'd4), 1'b1);
    #1;
    chk("loaduse_stall", a_stall, 1);
    tick();
    chk("bubble_ex_valid", a_exv, 0);
    chk("bubble_m", a_m, 0);
    chk("bubble_wb", a_wb, 0);
    chk("stall_released", a_stall, 0);
    tick();
    chk("held_add_issues", a_exv, 1);
    chk("held_add_rd", a_rdf, 4);
    chk("held_add_wb", a_wb, 2'b10);

    id(i_type(6'b100011, 5'd1, 5'd2, 16'h0000), 1'b1);
    tick();
    id(r_type(5'd5, 5'd2, 5'd4), 1'b1);
    #1;
    chk("stall_rt_rtype", a_stall, 1);
    id(i_type(6'b001101, 5'd5, 5'd2, 16'h0001), 1'b1);
    #1;
    chk("no_stall_itype_rt", a_stall, 0);
    id(r_type(5'd2, 5'd5, 5'd4), 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_beats_stall", a_stall, 0);
    tick();
    flush = 1'b0;
    chk("flush_ex_valid", a_exv, 0);
    chk("flush_wb", a_wb, 0);
    chk("flush_npc_zero", a_npc, 0);

    id(i_type(6'b100011, 5'd1, 5'd0, 16'h0000), 1'b1);
    tick();
    id(r_type(5'd0, 5'd5, 5'd4), 1'b1);
    #1;
    chk("lw_r0_no_stall", a_stall, 0);
    tick();
    chk("lw_r0_next_issues", a_exv, 1);

    id(i_type(6'b001000, 5'd0, 5'd1, 16'h8000), 1'b1);
    tick();
    chk("addi_sext", a_ext, 32'hFFFF_8000);
    chk("addi_aluop", a_aluop, 2'b00);
    chk("addi_alusrc", a_alusrc, 1);
    chk("addi_wb", a_wb, 2'b10);
    chk("b_addi_sext", b_ext, 64'hFFFF_FFFF_FFFF_8000);

    id(i_type(6'b001101, 5'd0, 5'd1, 16'h8000), 1'b1);
    tick();
    chk("ori_zext", a_ext, 32'h0000_8000);
    chk("ori_aluop", a_aluop, 2'b11);
    chk("b_ori_zext", b_ext, 64'h0000_0000_0000_8000);

    id(32'hFC00_0000, 1'b1);
    tick();
    chk("unknown_op_nop_wb", a_wb, 0);
    chk("unknown_op_aluop", a_aluop, 0);

    id(32'h0, 1'b0);
    wb(1'b1, 5'd7, 32'h0000_0011);
    tick();
    id(r_type(5'd7, 5'd0, 5'd8), 1'b1);
    wb(1'b1, 5'd7, 32'h0000_00A5);
`ifdef ID_BYPASS_EN
    bypass_exp = 32'h0000_00A5;
`else
    bypass_exp = 32'h0000_0011;
`endif
    tick();
    chk("same_cycle_wb_read", a_rd1, {32'b0, bypass_exp});
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("wb_visible_next", a_rd1, 32'h0000_00A5);

    id(i_type(6'b100011, 5'd1, 5'd2, 16'h0000), 1'b1);
    tick();
    id(r_type(5'd2, 5'd5, 5'd4), 1'b1);
    #1;
    chk("pre_reset_stall", a_stall, 1);
    rst_n = 1'b0;
    #1;
    chk("midstall_rst_ex_valid", a_exv, 0);
    chk("midstall_rst_stall", a_stall, 0);
    chk("midstall_rst_m", a_m, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
